rvh_l1d_amo_exec: RTL and testbench
===================================

Name: rvh_l1d_amo_exec

Overview:
Bank-side responder for atomic requests issued by the L1D AMO controller through the store buffer path.
- Accepts one LR/SC/AMO request at a time.
- Performs read, ALU modify and write on the bank data port.
- Returns the architectural rd value on the ROB writeback port, which the AMO controller watches to leave its wait state.
- One request in flight; sits between the STB drain path and the L1D data bank.

Parameters:
XLEN, 64, data width (only 64 supported)
PADDR_WIDTH, 56, physical address width
ROB_TAG_WIDTH, 7, ROB tag width
PREG_TAG_WIDTH, 7, physical dest register tag width
STU_OP_WIDTH, 5, store-unit opcode width (STU_* encodings from uop_encoding_pkg)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
amo_req_vld_i  in  1  AMO request valid
amo_req_rdy_o  out  1  request ready; 1 only in IDLE
amo_req_rob_tag_i  in  ROB_TAG_WIDTH  ROB tag
amo_req_prd_i  in  PREG_TAG_WIDTH  destination preg
amo_req_opcode_i  in  STU_OP_WIDTH  STU_LR*/SC*/AMO* opcode
amo_req_paddr_i  in  PADDR_WIDTH  naturally aligned address
amo_req_data_i  in  XLEN  rs2 operand
amo_req_sc_rt_check_succ_i  in  1  SC reservation check result, sampled at handshake
bank_rd_req_vld_o  out  1  bank read request
bank_rd_req_rdy_i  in  1  bank read ready
bank_rd_req_paddr_o  out  PADDR_WIDTH  doubleword-aligned read address (paddr[2:0]=0)
bank_rd_resp_vld_i  in  1  read data valid
bank_rd_resp_data_i  in  XLEN  read doubleword
bank_wr_req_vld_o  out  1  bank write request
bank_wr_req_rdy_i  in  1  bank write ready
bank_wr_req_paddr_o  out  PADDR_WIDTH  doubleword-aligned write address
bank_wr_req_data_o  out  XLEN  write doubleword
bank_wr_req_byte_mask_o  out  XLEN/8  byte enables
rob_wb_vld_o  out  1  one-cycle writeback pulse, no backpressure
rob_wb_rob_tag_o  out  ROB_TAG_WIDTH  captured rob tag
rob_wb_prd_o  out  PREG_TAG_WIDTH  captured prd
rob_wb_data_o  out  XLEN  rd value
busy_o  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - State is IDLE.
  - All vld outputs are 0 and busy_o is 0.
  - Data outputs are 0.
  - A request in flight when rst asserts is dropped: no write, no writeback.
- States and transitions:
  - IDLE: rdy=1. On handshake, capture all request fields and decode is_lr, is_sc, is_word (W opcodes) and alu_op.
    - SC with succ=1 goes to WR_REQ.
    - SC with succ=0 goes to RESP.
    - All other opcodes go to RD_REQ.
  - RD_REQ: bank_rd_req_vld_o=1 and held stable until bank_rd_req_rdy_i. On handshake, go to RD_WAIT.
  - RD_WAIT: wait for bank_rd_resp_vld_i, then capture old = bank_rd_resp_data_i.
    - LR goes to RESP.
    - AMO goes to WR_REQ.
    - bank_rd_resp_vld_i in any other state is ignored.
  - WR_REQ: bank_wr_req_vld_o=1 and held stable until rdy. On handshake, go to RESP.
  - RESP: rob_wb_vld_o=1 for exactly one cycle, then IDLE.
- Word select and read value:
  - W ops use lane = paddr[2]; oldw = old[32*lane +: 32].
  - rd value is sign-extended oldw for W ops and old for D ops.
- ALU (new value):
  - SWAP: rs2.
  - ADD: wrap-around addition at operand width.
  - AND, OR, XOR: bitwise.
  - MAX, MIN: signed compare.
  - MAXU, MINU: unsigned compare.
  - W ops use rs2[31:0] and oldw.
- Write data and byte mask:
  - D ops: write data = new value, mask = 8'hFF.
  - W ops: new word replicated in both halves; mask = 8'h0F for lane 0, 8'hF0 for lane 1.
  - SC uses rs2 as the new value with the same lane rules.
- Writeback data:
  - LR and AMO: rd value.
  - SC success: 0.
  - SC fail: 1.
- Latency with zero-wait bank (rdy=1, read response 1 cycle after read handshake), counted from the request handshake in cycle 0:
  - AMO: read request in cycle 1, write request in cycle 3, rob_wb_vld_o in cycle 4.
  - LR: rob_wb_vld_o in cycle 3.
  - SC success: write in cycle 1, writeback in cycle 2.
  - SC fail: writeback in cycle 1.
- Simultaneous events: a new request is never accepted in RESP; rdy stays 0 until back in IDLE. Back-to-back requests therefore have a minimum 1-cycle gap after the writeback cycle.
- Alignment: a misaligned paddr (W: paddr[1:0]!=0; D: paddr[2:0]!=0) or a non-AMO opcode at handshake triggers a simulation assertion (non-SYNTHESIS builds). Hardware behaviour in that case is undefined.

Optional Feature:
RVH_L1D_AMO_EXEC_ALU_PIPE_EN
- When defined: an extra state ALU after RD_WAIT registers the new value, so the ALU result path is cut from the bank read data. AMO latency grows by 1 cycle (write in cycle 4, writeback in cycle 5). LR, SC and SC-fail latencies are unchanged.
- When undefined: the ALU is combinational off the captured old value, with the timing above.

Test Plan:
1. AMOADDD, mem=5, rs2=3, zero-wait bank -> write data 8, mask FF in cycle 3; wb_vld in cycle 4 with data 5 and matching tag/prd.
2. AMOMAXW at paddr lane 1, old word 0xFFFFFFFF, rs2=1 -> write 0x00000001 with mask F0; wb data 0xFFFFFFFFFFFFFFFF. Repeat with AMOMAXUW -> write 0xFFFFFFFF, same wb data.
3. SCD with succ=0 -> no read, no write, wb data 1 in cycle 1. SCD with succ=1, rs2=0xAB -> write 0xAB mask FF in cycle 1, wb data 0 in cycle 2.
4. LRW lane 0, mem low word 0x80000000 -> one read, no write, wb data 0xFFFFFFFF80000000.
5. AMOSWAPD with bank_rd_req_rdy_i held 0 for 4 cycles and read response delayed 3 cycles -> vld and address stable while stalled; exactly one read, one write and one wb; amo_req_rdy_o stays 0 until after wb.
6. Assert rst while in WR_REQ -> all vld outputs drop immediately (asynchronous), no wb, busy_o=0; a new request is accepted normally after rst deasserts.

Source files
------------

// File: rtl/rvh_l1d_amo_exec.sv
// Bank-side LR/SC/AMO executor: one request in flight, read -> ALU -> write -> ROB writeback.
// Optional RVH_L1D_AMO_EXEC_ALU_PIPE_EN registers the ALU result in an extra ALU state.
module rvh_l1d_amo_exec #(
  parameter int XLEN           = 64,
  parameter int PADDR_WIDTH    = 56,
  parameter int ROB_TAG_WIDTH  = 7,
  parameter int PREG_TAG_WIDTH = 7,
  parameter int STU_OP_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      amo_req_vld_i,
  output logic                      amo_req_rdy_o,
  input  logic [ROB_TAG_WIDTH-1:0]  amo_req_rob_tag_i,
  input  logic [PREG_TAG_WIDTH-1:0] amo_req_prd_i,
  input  logic [STU_OP_WIDTH-1:0]   amo_req_opcode_i,
  input  logic [PADDR_WIDTH-1:0]    amo_req_paddr_i,
  input  logic [XLEN-1:0]           amo_req_data_i,
  input  logic                      amo_req_sc_rt_check_succ_i,
  output logic                      bank_rd_req_vld_o,
  input  logic                      bank_rd_req_rdy_i,
  output logic [PADDR_WIDTH-1:0]    bank_rd_req_paddr_o,
  input  logic                      bank_rd_resp_vld_i,
  input  logic [XLEN-1:0]           bank_rd_resp_data_i,
  output logic                      bank_wr_req_vld_o,
  input  logic                      bank_wr_req_rdy_i,
  output logic [PADDR_WIDTH-1:0]    bank_wr_req_paddr_o,
  output logic [XLEN-1:0]           bank_wr_req_data_o,
  output logic [XLEN/8-1:0]         bank_wr_req_byte_mask_o,
  output logic                      rob_wb_vld_o,
  output logic [ROB_TAG_WIDTH-1:0]  rob_wb_rob_tag_o,
  output logic [PREG_TAG_WIDTH-1:0] rob_wb_prd_o,
  output logic [XLEN-1:0]           rob_wb_data_o,
  output logic                      busy_o
);

  localparam int MASK_W = XLEN / 8;

  // STU opcode encodings; odd codes are the doubleword variants.
  localparam logic [STU_OP_WIDTH-1:0] STU_LRW      = 5'd4;
  localparam logic [STU_OP_WIDTH-1:0] STU_LRD      = 5'd5;
  localparam logic [STU_OP_WIDTH-1:0] STU_SCW      = 5'd6;
  localparam logic [STU_OP_WIDTH-1:0] STU_SCD      = 5'd7;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAPW = 5'd8;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAPD = 5'd9;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOADDW  = 5'd10;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOADDD  = 5'd11;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOANDW  = 5'd12;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOANDD  = 5'd13;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOORW   = 5'd14;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOORD   = 5'd15;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOXORW  = 5'd16;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOXORD  = 5'd17;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXW  = 5'd18;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXD  = 5'd19;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXUW = 5'd20;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXUD = 5'd21;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINW  = 5'd22;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMIND  = 5'd23;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINUW = 5'd24;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINUD = 5'd25;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_ALU, S_WR_REQ, S_RESP
  } state_e;

  typedef enum logic [3:0] {
    ALU_SWAP, ALU_ADD, ALU_AND, ALU_OR, ALU_XOR,
    ALU_MAX, ALU_MAXU, ALU_MIN, ALU_MINU
  } alu_op_e;

  state_e                    state_q, state_d;
  logic [ROB_TAG_WIDTH-1:0]  rob_tag_q;
  logic [PREG_TAG_WIDTH-1:0] prd_q;
  logic                      is_lr_q, is_sc_q, is_word_q, sc_succ_q;
  alu_op_e                   alu_op_q;
  logic [PADDR_WIDTH-1:2]    paddr_q;
  logic [XLEN-1:0]           rs2_q, old_q;

  logic    req_hs;
  logic    dec_is_lr, dec_is_sc;
  alu_op_e dec_alu;

  assign req_hs = amo_req_vld_i & amo_req_rdy_o;

  always_comb begin
    dec_is_lr = (amo_req_opcode_i == STU_LRW) || (amo_req_opcode_i == STU_LRD);
    dec_is_sc = (amo_req_opcode_i == STU_SCW) || (amo_req_opcode_i == STU_SCD);
    dec_alu   = ALU_SWAP;
    case (amo_req_opcode_i)
      STU_AMOADDW,  STU_AMOADDD:  dec_alu = ALU_ADD;
      STU_AMOANDW,  STU_AMOANDD:  dec_alu = ALU_AND;
      STU_AMOORW,   STU_AMOORD:   dec_alu = ALU_OR;
      STU_AMOXORW,  STU_AMOXORD:  dec_alu = ALU_XOR;
      STU_AMOMAXW,  STU_AMOMAXD:  dec_alu = ALU_MAX;
      STU_AMOMAXUW, STU_AMOMAXUD: dec_alu = ALU_MAXU;
      STU_AMOMINW,  STU_AMOMIND:  dec_alu = ALU_MIN;
      STU_AMOMINUW, STU_AMOMINUD: dec_alu = ALU_MINU;
      default:                    dec_alu = ALU_SWAP;
    endcase
  end

  // Word ops are sign-extended to XLEN so a single set of compares serves W and D;
  // sign extension preserves unsigned 32-bit ordering as well.
  logic            lane;
  logic [31:0]     old_w;
  logic [XLEN-1:0] op_a, op_b, alu_new, wr_src;
  logic            slt, ult;

  assign lane  = paddr_q[2];
  assign old_w = lane ? old_q[63:32] : old_q[31:0];
  assign op_a  = is_word_q ? {{(XLEN-32){old_w[31]}}, old_w} : old_q;
  assign op_b  = is_word_q ? {{(XLEN-32){rs2_q[31]}}, rs2_q[31:0]} : rs2_q;
  assign slt   = $signed(op_a) < $signed(op_b);
  assign ult   = op_a < op_b;

  always_comb begin
    alu_new = op_b;
    case (alu_op_q)
      ALU_SWAP: alu_new = op_b;
      ALU_ADD:  alu_new = op_a + op_b;
      ALU_AND:  alu_new = op_a & op_b;
      ALU_OR:   alu_new = op_a | op_b;
      ALU_XOR:  alu_new = op_a ^ op_b;
      ALU_MAX:  alu_new = slt ? op_b : op_a;
      ALU_MAXU: alu_new = ult ? op_b : op_a;
      ALU_MIN:  alu_new = slt ? op_a : op_b;
      ALU_MINU: alu_new = ult ? op_a : op_b;
      default:  alu_new = op_b;
    endcase
  end

`ifdef RVH_L1D_AMO_EXEC_ALU_PIPE_EN
  logic [XLEN-1:0] new_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   new_q <= '0;
    else if (state_q == S_ALU) new_q <= alu_new;
  end
  assign wr_src = is_sc_q ? rs2_q : new_q;
`else
  assign wr_src = is_sc_q ? rs2_q : alu_new;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (amo_req_vld_i) begin
          if (dec_is_sc) state_d = amo_req_sc_rt_check_succ_i ? S_WR_REQ : S_RESP;
          else           state_d = S_RD_REQ;
        end
      S_RD_REQ:  if (bank_rd_req_rdy_i) state_d = S_RD_WAIT;
      S_RD_WAIT:
        if (bank_rd_resp_vld_i) begin
`ifdef RVH_L1D_AMO_EXEC_ALU_PIPE_EN
          state_d = is_lr_q ? S_RESP : S_ALU;
`else
          state_d = is_lr_q ? S_RESP : S_WR_REQ;
`endif
        end
      S_ALU:     state_d = S_WR_REQ;
      S_WR_REQ:  if (bank_wr_req_rdy_i) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rob_tag_q <= '0;
      prd_q     <= '0;
      is_lr_q   <= 1'b0;
      is_sc_q   <= 1'b0;
      is_word_q <= 1'b0;
      sc_succ_q <= 1'b0;
      alu_op_q  <= ALU_SWAP;
      paddr_q   <= '0;
      rs2_q     <= '0;
      old_q     <= '0;
    end else begin
      if (req_hs) begin
        rob_tag_q <= amo_req_rob_tag_i;
        prd_q     <= amo_req_prd_i;
        is_lr_q   <= dec_is_lr;
        is_sc_q   <= dec_is_sc;
        is_word_q <= ~amo_req_opcode_i[0];
        sc_succ_q <= amo_req_sc_rt_check_succ_i;
        alu_op_q  <= dec_alu;
        paddr_q   <= amo_req_paddr_i[PADDR_WIDTH-1:2];
        rs2_q     <= amo_req_data_i;
      end
      if (state_q == S_RD_WAIT && bank_rd_resp_vld_i) old_q <= bank_rd_resp_data_i;
    end
  end

  logic [PADDR_WIDTH-1:0] dw_addr;
  logic [XLEN-1:0]        wr_data, wb_data;
  logic [MASK_W-1:0]      wr_mask;

  assign dw_addr = {paddr_q[PADDR_WIDTH-1:3], 3'b000};
  assign wr_data = is_word_q ? {2{wr_src[31:0]}} : wr_src;
  assign wr_mask = !is_word_q ? {MASK_W{1'b1}} :
                   lane       ? {{(MASK_W/2){1'b1}}, {(MASK_W/2){1'b0}}} :
                                {{(MASK_W/2){1'b0}}, {(MASK_W/2){1'b1}}};
  assign wb_data = is_sc_q ? {{(XLEN-1){1'b0}}, ~sc_succ_q} : op_a;

  assign amo_req_rdy_o     = (state_q == S_IDLE);
  assign busy_o            = (state_q != S_IDLE);
  assign bank_rd_req_vld_o = (state_q == S_RD_REQ);
  assign bank_wr_req_vld_o = (state_q == S_WR_REQ);
  assign rob_wb_vld_o      = (state_q == S_RESP);

  // Payloads are forced to zero outside their valid cycle so idle outputs stay quiet.
  assign bank_rd_req_paddr_o     = bank_rd_req_vld_o ? dw_addr : '0;
  assign bank_wr_req_paddr_o     = bank_wr_req_vld_o ? dw_addr : '0;
  assign bank_wr_req_data_o      = bank_wr_req_vld_o ? wr_data : '0;
  assign bank_wr_req_byte_mask_o = bank_wr_req_vld_o ? wr_mask : '0;
  assign rob_wb_rob_tag_o        = rob_wb_vld_o ? rob_tag_q : '0;
  assign rob_wb_prd_o            = rob_wb_vld_o ? prd_q : '0;
  assign rob_wb_data_o           = rob_wb_vld_o ? wb_data : '0;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && req_hs) begin
      assert (amo_req_opcode_i inside {[STU_LRW:STU_AMOMINUD]});
      assert (amo_req_opcode_i[0] ? (amo_req_paddr_i[2:0] == 3'b000)
                                  : (amo_req_paddr_i[1:0] == 2'b00));
    end
  end
`endif

endmodule

// File: tb/tb_rvh_l1d_amo_exec.sv
// Directed bench for rvh_l1d_amo_exec with a behavioural AMO model, bank responder and per-cycle checker.
module tb_rvh_l1d_amo_exec;

  localparam logic [4:0] LRW = 5'd4, LRD = 5'd5, SCW = 5'd6, SCD = 5'd7;
  localparam logic [4:0] SWAPW = 5'd8, SWAPD = 5'd9, ADDW = 5'd10, ADDD = 5'd11;
  localparam logic [4:0] ANDW = 5'd12, ORD = 5'd15, XORW = 5'd16, XORD = 5'd17;
  localparam logic [4:0] MAXW = 5'd18, MAXUW = 5'd20, MINW = 5'd22, MINUD = 5'd25;
`ifdef RVH_L1D_AMO_EXEC_ALU_PIPE_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        amo_req_vld_i = 1'b0, amo_req_rdy_o;
  logic [6:0]  amo_req_rob_tag_i = '0, amo_req_prd_i = '0;
  logic [4:0]  amo_req_opcode_i = '0;
  logic [55:0] amo_req_paddr_i = '0;
  logic [63:0] amo_req_data_i = '0;
  logic        amo_req_sc_rt_check_succ_i = 1'b0;
  logic        bank_rd_req_vld_o, bank_rd_req_rdy_i = 1'b1;
  logic [55:0] bank_rd_req_paddr_o;
  logic        bank_rd_resp_vld_i = 1'b0;
  logic [63:0] bank_rd_resp_data_i = '0;
  logic        bank_wr_req_vld_o, bank_wr_req_rdy_i = 1'b1;
  logic [55:0] bank_wr_req_paddr_o;
  logic [63:0] bank_wr_req_data_o;
  logic [7:0]  bank_wr_req_byte_mask_o;
  logic        rob_wb_vld_o;
  logic [6:0]  rob_wb_rob_tag_o, rob_wb_prd_o;
  logic [63:0] rob_wb_data_o;
  logic        busy_o;

  rvh_l1d_amo_exec dut (
    .clk(clk), .rst(rst),
    .amo_req_vld_i(amo_req_vld_i), .amo_req_rdy_o(amo_req_rdy_o),
    .amo_req_rob_tag_i(amo_req_rob_tag_i), .amo_req_prd_i(amo_req_prd_i),
    .amo_req_opcode_i(amo_req_opcode_i), .amo_req_paddr_i(amo_req_paddr_i),
    .amo_req_data_i(amo_req_data_i), .amo_req_sc_rt_check_succ_i(amo_req_sc_rt_check_succ_i),
    .bank_rd_req_vld_o(bank_rd_req_vld_o), .bank_rd_req_rdy_i(bank_rd_req_rdy_i),
    .bank_rd_req_paddr_o(bank_rd_req_paddr_o),
    .bank_rd_resp_vld_i(bank_rd_resp_vld_i), .bank_rd_resp_data_i(bank_rd_resp_data_i),
    .bank_wr_req_vld_o(bank_wr_req_vld_o), .bank_wr_req_rdy_i(bank_wr_req_rdy_i),
    .bank_wr_req_paddr_o(bank_wr_req_paddr_o), .bank_wr_req_data_o(bank_wr_req_data_o),
    .bank_wr_req_byte_mask_o(bank_wr_req_byte_mask_o),
    .rob_wb_vld_o(rob_wb_vld_o), .rob_wb_rob_tag_o(rob_wb_rob_tag_o),
    .rob_wb_prd_o(rob_wb_prd_o), .rob_wb_data_o(rob_wb_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem [8];
  bit          in_flight = 0;
  int          hs_cyc;
  bit          e_rd, e_wr, lat_chk;
  logic [63:0] e_wdata, e_wb, e_mem;
  logic [7:0]  e_mask;
  logic [55:0] e_addr;
  logic [6:0]  e_tag, e_prd;
  int          e_wr_lat, e_wb_lat;
  int          rd_stall = 0, wr_stall = 0, rd_delay = 1;
  int          rd_stalled = 0, wr_stalled = 0, rd_timer = 0;
  int          rd_cnt = 0, wr_cnt = 0, wr_tot = 0, wb_tot = 0;
  logic [63:0] last_wdata, last_wb;
  logic [7:0]  last_mask;
  int          tag_ctr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Architectural meaning of each op, computed directly on integers.
  function automatic void model(input logic [4:0] op, input logic [63:0] old, input logic [63:0] rs2,
                                input logic lane, input logic succ, output bit do_rd, output bit do_wr,
                                output logic [63:0] wdata, output logic [7:0] mask, output logic [63:0] rd);
    bit w, lr, sc;
    int fn;
    logic [31:0] ow, rw;
    longint so, sr;
    logic [63:0] n;
    w  = (op % 2 == 0);
    lr = (op == LRW) || (op == LRD);
    sc = (op == SCW) || (op == SCD);
    fn = (int'(op) - 8) / 2;
    ow = lane ? old[63:32] : old[31:0];
    rw = rs2[31:0];
    so = w ? longint'($signed(ow)) : $signed(old);
    sr = w ? longint'($signed(rw)) : $signed(rs2);
    n  = rs2;
    if (!sc && !lr) begin
      case (fn)
        1: n = so + sr;
        2: n = so & sr;
        3: n = so | sr;
        4: n = so ^ sr;
        5: n = (so > sr) ? so : sr;
        6: n = w ? 64'((ow > rw) ? ow : rw) : ((old > rs2) ? old : rs2);
        7: n = (so < sr) ? so : sr;
        8: n = w ? 64'((ow < rw) ? ow : rw) : ((old < rs2) ? old : rs2);
        default: n = rs2;
      endcase
    end
    rd    = sc ? (succ ? 64'd0 : 64'd1) : 64'(so);
    do_rd = !sc;
    do_wr = !lr && (!sc || succ);
    if (w) begin wdata = {n[31:0], n[31:0]}; mask = lane ? 8'hF0 : 8'h0F; end
    else   begin wdata = n;                  mask = 8'hFF; end
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Bank responder + per-cycle compare, all sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      rd_timer = 0; rd_stalled = 0; wr_stalled = 0;
      bank_rd_resp_vld_i = 1'b0;
      bank_rd_req_rdy_i = 1'b1; bank_wr_req_rdy_i = 1'b1;
    end else begin
      if (amo_req_vld_i && amo_req_rdy_o) begin rd_cnt = 0; wr_cnt = 0; end
      chk("req_rdy", amo_req_rdy_o, !in_flight);
      chk("busy", busy_o, in_flight);
      bank_rd_resp_vld_i = 1'b0;
      if (rd_timer > 0) begin
        rd_timer--;
        if (rd_timer == 0) begin bank_rd_resp_vld_i = 1'b1; bank_rd_resp_data_i = mem[e_addr[5:3]]; end
      end
      bank_rd_req_rdy_i = !(bank_rd_req_vld_o && rd_stalled < rd_stall);
      bank_wr_req_rdy_i = !(bank_wr_req_vld_o && wr_stalled < wr_stall);
      if (bank_rd_req_vld_o) begin
        chk("rd_expected", 1, e_rd);
        chk("rd_addr", bank_rd_req_paddr_o, e_addr);
        if (bank_rd_req_rdy_i) begin rd_cnt++; rd_timer = rd_delay; rd_stalled = 0; end
        else rd_stalled++;
      end
      if (bank_wr_req_vld_o) begin
        chk("wr_expected", 1, e_wr);
        chk("wr_addr", bank_wr_req_paddr_o, e_addr);
        chk("wr_data", bank_wr_req_data_o, e_wdata);
        chk("wr_mask", bank_wr_req_byte_mask_o, e_mask);
        if (bank_wr_req_rdy_i) begin
          if (lat_chk) chk("wr_lat", cyc - hs_cyc, e_wr_lat);
          wr_cnt++; wr_tot++; wr_stalled = 0;
          mem[e_addr[5:3]] = merge(mem[e_addr[5:3]], bank_wr_req_data_o, bank_wr_req_byte_mask_o);
          last_wdata = bank_wr_req_data_o; last_mask = bank_wr_req_byte_mask_o;
        end else wr_stalled++;
      end
      if (rob_wb_vld_o) begin
        wb_tot++;
        chk("wb_expected", in_flight, 1);
        chk("wb_tag", rob_wb_rob_tag_o, e_tag);
        chk("wb_prd", rob_wb_prd_o, e_prd);
        chk("wb_data", rob_wb_data_o, e_wb);
        chk("rd_count", rd_cnt, e_rd);
        chk("wr_count", wr_cnt, e_wr);
        chk("mem_after", mem[e_addr[5:3]], e_mem);
        if (lat_chk) chk("wb_lat", cyc - hs_cyc, e_wb_lat);
        last_wb = rob_wb_data_o;
        in_flight = 0;
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [55:0] pa, input logic [63:0] rs2,
                       input logic succ, input int rstall, input int rdel, input bit lchk);
    logic [63:0] old, wd, rdv;
    logic [7:0]  mk;
    bit dr, dw;
    int w;
    old = mem[pa[5:3]];
    model(op, old, rs2, pa[2], succ, dr, dw, wd, mk, rdv);
    e_rd = dr; e_wr = dw; e_wdata = wd; e_mask = mk; e_wb = rdv;
    e_mem  = dw ? merge(old, wd, mk) : old;
    e_addr = {pa[55:3], 3'b000};
    tag_ctr++;
    e_tag = 7'(tag_ctr); e_prd = 7'(tag_ctr * 5 + 3);
    if (op == LRW || op == LRD)      begin e_wr_lat = -1; e_wb_lat = 3; end
    else if (op == SCW || op == SCD) begin e_wr_lat = succ ? 1 : -1; e_wb_lat = succ ? 2 : 1; end
    else                             begin e_wr_lat = 3 + P; e_wb_lat = 4 + P; end
    rd_stall = rstall; rd_delay = rdel; lat_chk = lchk;
    @(negedge clk);
    w = 0;
    while (!amo_req_rdy_o && w < 20) begin @(negedge clk); w++; end
    chk("req_rdy_wait", amo_req_rdy_o, 1);
    amo_req_vld_i = 1'b1; amo_req_opcode_i = op; amo_req_paddr_i = pa; amo_req_data_i = rs2;
    amo_req_sc_rt_check_succ_i = succ; amo_req_rob_tag_i = e_tag; amo_req_prd_i = e_prd;
    hs_cyc = cyc;
    @(posedge clk); #1;
    amo_req_vld_i = 1'b0;
    in_flight = 1;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (in_flight && w < 40) begin @(negedge clk); #1; w++; end
    chk("wb_timeout", in_flight, 0);
  endtask

  task automatic run(input logic [4:0] op, input logic [55:0] pa, input logic [63:0] rs2, input logic succ);
    issue(op, pa, rs2, succ, 0, 1, 1);
    wait_done();
  endtask

  logic [4:0]  t_op  [6] = '{MINW, MINUD, ANDW, ORD, XORW, ADDW};
  logic [55:0] t_pa  [6] = '{56'h2030, 56'h2038, 56'h2034, 56'h2000, 56'h2008, 56'h2010};
  logic [63:0] t_old [6] = '{64'h0, 64'h5, 64'hF0F0_1234_0000_0000, 64'h00FF, 64'hAAAA_5555_0000_FFFF, 64'h1_7FFF_FFFF};
  logic [63:0] t_rs2 [6] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'h0FF0_0FF0,
                             64'hFF00, 64'h0000_FFFF, 64'h1};

  initial begin
    int wb0, wr0, w;
    logic [63:0] saved;
    for (int i = 0; i < 8; i++) mem[i] = 64'h0;
    #1 rst = 1'b1;
    #1;
    chk("rst_rdy", amo_req_rdy_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_rd_vld", bank_rd_req_vld_o, 0);
    chk("rst_wr_vld", bank_wr_req_vld_o, 0);
    chk("rst_wb_vld", rob_wb_vld_o, 0);
    chk("rst_wb_data", rob_wb_data_o, 0);
    chk("rst_wr_data", bank_wr_req_data_o, 0);
    chk("rst_wr_mask", bank_wr_req_byte_mask_o, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    mem[0] = 64'd5;
    run(ADDD, 56'h1000, 64'd3, 0);
    chk("t1_wdata", last_wdata, 64'd8);
    chk("t1_mask", last_mask, 8'hFF);
    chk("t1_wb", last_wb, 64'd5);

    mem[1] = 64'hFFFF_FFFF_1234_5678;
    run(MAXW, 56'h100C, 64'd1, 0);
    chk("t2_max_wdata", last_wdata, 64'h0000_0001_0000_0001);
    chk("t2_max_mask", last_mask, 8'hF0);
    chk("t2_max_wb", last_wb, 64'hFFFF_FFFF_FFFF_FFFF);
    mem[1] = 64'hFFFF_FFFF_1234_5678;
    run(MAXUW, 56'h100C, 64'd1, 0);
    chk("t2_maxu_wdata", last_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_maxu_wb", last_wb, 64'hFFFF_FFFF_FFFF_FFFF);

    mem[2] = 64'h1111;
    wr0 = wr_tot;
    run(SCD, 56'h1010, 64'hAB, 0);
    chk("t3_fail_wb", last_wb, 64'd1);
    chk("t3_fail_nowrite", wr_tot, wr0);
    run(SCD, 56'h1010, 64'hAB, 1);
    chk("t3_succ_wdata", last_wdata, 64'hAB);
    chk("t3_succ_mask", last_mask, 8'hFF);
    chk("t3_succ_wb", last_wb, 64'd0);
    run(SCW, 56'h1014, 64'h77, 1);

    mem[3] = 64'h1234_5678_8000_0000;
    run(LRW, 56'h1018, 64'h0, 0);
    chk("t4_wb", last_wb, 64'hFFFF_FFFF_8000_0000);
    run(LRD, 56'h1018, 64'h0, 0);

    mem[4] = 64'hDEAD_BEEF_0000_0001;
    issue(SWAPD, 56'h1020, 64'h0123_4567_89AB_CDEF, 0, 4, 3, 0);
    wait_done();
    chk("t5_wb", last_wb, 64'hDEAD_BEEF_0000_0001);
    chk("t5_mem", mem[4], 64'h0123_4567_89AB_CDEF);

    for (int i = 0; i < 6; i++) begin
      mem[t_pa[i][5:3]] = t_old[i];
      run(t_op[i], t_pa[i], t_rs2[i], 0);
    end

    // Reset while the write is stalled in WR_REQ.
    mem[5] = 64'h5555;
    saved = mem[5];
    wb0 = wb_tot;
    wr_stall = 1000;
    issue(SWAPD, 56'h1028, 64'h9999, 0, 0, 1, 0);
    w = 0;
    while (!bank_wr_req_vld_o && w < 20) begin @(negedge clk); w++; end
    chk("t6_reached_wr", bank_wr_req_vld_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_wr_vld_drop", bank_wr_req_vld_o, 0);
    chk("t6_wb_vld_drop", rob_wb_vld_o, 0);
    chk("t6_busy_drop", busy_o, 0);
    in_flight = 0;
    wr_stall = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_wb", wb_tot, wb0);
    chk("t6_no_write", mem[5], saved);
    run(XORD, 56'h1028, 64'h0F0F, 0);
    chk("t6_after_wb", last_wb, 64'h5555);
    chk("t6_after_mem", mem[5], 64'h5A5A);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
